// File: rtl/mem_burst.sv
// Parametrised single-port memory with single and wrapping burst read/write.
// Registered read data with valid strobe; busy/done/err status for sequencing.
module mem_burst #(
    parameter int DATA_W = 5,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] address,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BWR,
        BRD
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                out_valid_q, out_valid_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                in_range;
    logic [IDX_W-1:0]    addr_idx;
    logic [IDX_W-1:0]    ptr_idx;

    // Pointer wraps at DEPTH, not at the address-width boundary
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
    endfunction

    assign in_range = ({1'b0, address} < (ADDR_W + 1)'(DEPTH));
    assign addr_idx = address[IDX_W-1:0];
    assign ptr_idx  = ptr_q[IDX_W-1:0];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        mem_d       = mem_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else begin
                        if (mode[0]) begin
                            data_out_d  = mem_q[addr_idx];
                            out_valid_d = 1'b1;
                        end else begin
                            mem_d[addr_idx] = data_in;
                        end
                        if (!mode[1] || len == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = mode[0] ? BRD : BWR;
                            ptr_d   = wrap_inc(address);
                            rem_d   = len;
                        end
                    end
                end
            end
            BWR, BRD: begin
                if (state_q == BRD) begin
                    data_out_d  = mem_q[ptr_idx];
                    out_valid_d = 1'b1;
                end else begin
                    mem_d[ptr_idx] = data_in;
                end
                ptr_d = wrap_inc(ptr_q);
                // rem_q counts beats still to run, including this one
                if (rem_q == ADDR_W'(1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    rem_d = rem_q - ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            mem_q       <= '{default: '0};
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            mem_q       <= mem_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_burst.sv
// Directed bench for mem_burst: default 32x5 instance and a DEPTH=24 instance
// driven by the same stimulus.
module tb_mem_burst;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [4:0] address;
    logic [4:0] len;
    logic [4:0] data_in;

    logic [4:0] dout_a, dout_b;
    logic       ov_a, ov_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;
    logic       err_a, err_b;

    int checks = 0;
    int errors = 0;

    mem_burst u_a (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .address   (address),
        .len       (len),
        .data_in   (data_in),
        .data_out  (dout_a),
        .out_valid (ov_a),
        .busy      (busy_a),
        .done      (done_a),
        .err       (err_a)
    );

    mem_burst #(.DATA_W(5), .ADDR_W(5), .DEPTH(24)) u_b (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .address   (address),
        .len       (len),
        .data_in   (data_in),
        .data_out  (dout_b),
        .out_valid (ov_b),
        .busy      (busy_b),
        .done      (done_b),
        .err       (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic e, input logic [1:0] m, input logic [4:0] a,
                       input logic [4:0] l, input logic [4:0] d);
        en      = e;
        mode    = m;
        address = a;
        len     = l;
        data_in = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // status order: out_valid, busy, done, err
    task automatic chk_a(input string tag, input logic [4:0] d, input logic [3:0] st);
        chk({tag, ".data"}, 32'(dout_a), 32'(d));
        chk({tag, ".stat"}, 32'({ov_a, busy_a, done_a, err_a}), 32'(st));
    endtask

    initial begin
        rst = 1'b0;
        cmd(1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        chk_a("reset", 5'd0, 4'b0000);
        chk("reset_b", 32'({dout_b, ov_b, busy_b, done_b, err_b}), 32'd0);
        rst = 1'b1;

        // single writes
        cmd(1'b1, 2'b00, 5'd5, 5'd0, 5'd27);
        tick();
        chk_a("wr5", 5'd0, 4'b0010);
        cmd(1'b1, 2'b00, 5'd8, 5'd0, 5'd26);
        tick();
        cmd(1'b1, 2'b00, 5'd23, 5'd0, 5'd25);
        tick();
        chk_a("wr23", 5'd0, 4'b0010);

        // single reads
        cmd(1'b1, 2'b01, 5'd0, 5'd0, 5'd0);
        tick();
        chk_a("rd0", 5'd0, 4'b1010);
        cmd(1'b1, 2'b01, 5'd8, 5'd0, 5'd0);
        tick();
        chk_a("rd8", 5'd26, 4'b1010);
        cmd(1'b1, 2'b01, 5'd5, 5'd0, 5'd0);
        tick();
        chk_a("rd5", 5'd27, 4'b1010);
        cmd(1'b1, 2'b01, 5'd23, 5'd0, 5'd0);
        tick();
        chk_a("rd23", 5'd25, 4'b1010);

        // idle with en=0 holds data_out
        cmd(1'b0, 2'b01, 5'd8, 5'd0, 5'd0);
        tick();
        chk_a("idle_hold", 5'd25, 4'b0000);

        // burst write 30..1 (wraps 31->0)
        cmd(1'b1, 2'b10, 5'd30, 5'd3, 5'd1);
        tick();
        chk_a("bw_e0", 5'd25, 4'b0100);
        cmd(1'b0, 2'b00, 5'd0, 5'd0, 5'd2);
        tick();
        chk_a("bw_e1", 5'd25, 4'b0100);
        data_in = 5'd3;
        tick();
        chk_a("bw_e2", 5'd25, 4'b0100);
        data_in = 5'd4;
        tick();
        chk_a("bw_e3", 5'd25, 4'b0010);

        // burst read back, accepted at E(len+1)
        cmd(1'b1, 2'b11, 5'd30, 5'd3, 5'd0);
        tick();
        chk_a("br_e0", 5'd1, 4'b1100);
        en = 1'b0;
        tick();
        chk_a("br_e1", 5'd2, 4'b1100);
        tick();
        chk_a("br_e2_wrap", 5'd3, 4'b1100);
        tick();
        chk_a("br_e3", 5'd4, 4'b1010);
        tick();
        chk_a("br_after", 5'd4, 4'b0000);

        // command during busy is ignored, data_in still consumed
        cmd(1'b1, 2'b10, 5'd10, 5'd2, 5'd7);
        tick();
        cmd(1'b1, 2'b00, 5'd20, 5'd0, 5'd9);
        tick();
        chk_a("busy_ign", 5'd4, 4'b0100);
        data_in = 5'd8;
        tick();
        chk_a("busy_done", 5'd4, 4'b0010);
        cmd(1'b1, 2'b01, 5'd20, 5'd0, 5'd0);
        tick();
        chk_a("rd20", 5'd0, 4'b1010);
        address = 5'd10;
        tick();
        chk_a("rd10", 5'd7, 4'b1010);
        address = 5'd11;
        tick();
        chk_a("rd11", 5'd9, 4'b1010);
        address = 5'd12;
        tick();
        chk_a("rd12", 5'd8, 4'b1010);

        // len=0 burst read acts as a single read
        cmd(1'b1, 2'b11, 5'd5, 5'd0, 5'd0);
        tick();
        chk_a("br_len0", 5'd27, 4'b1010);
        en = 1'b0;
        tick();
        chk_a("br_len0_after", 5'd27, 4'b0000);

        // reset mid-burst
        cmd(1'b1, 2'b10, 5'd0, 5'd7, 5'd5);
        tick();
        cmd(1'b0, 2'b00, 5'd0, 5'd0, 5'd6);
        tick();
        data_in = 5'd7;
        tick();
        chk_a("mid_busy", 5'd27, 4'b0100);
        rst = 1'b0;
        tick();
        chk_a("mid_rst", 5'd0, 4'b0000);
        rst = 1'b1;
        tick();
        chk_a("mid_idle", 5'd0, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            cmd(1'b1, 2'b01, 5'(i), 5'd0, 5'd0);
            tick();
            chk_a($sformatf("rst_rd%0d", i), 5'd0, 4'b1010);
        end
        cmd(1'b1, 2'b01, 5'd5, 5'd0, 5'd0);
        tick();
        chk_a("rst_rd5_cleared", 5'd0, 4'b1010);

        // DEPTH=24: out-of-range single write
        cmd(1'b1, 2'b00, 5'd26, 5'd0, 5'd13);
        tick();
        chk("oor_b", 32'({ov_b, busy_b, done_b, err_b}), 32'b0001);
        chk("oor_a", 32'({ov_a, busy_a, done_a, err_a}), 32'b0010);
        en = 1'b0;
        tick();
        chk("oor_pulse", 32'({ov_b, busy_b, done_b, err_b}), 32'b0000);

        // DEPTH=24: burst write at 22 wraps to 0
        cmd(1'b1, 2'b10, 5'd22, 5'd3, 5'd21);
        tick();
        chk("b24_busy", 32'({busy_b, err_b}), 32'b10);
        cmd(1'b0, 2'b00, 5'd0, 5'd0, 5'd22);
        tick();
        data_in = 5'd23;
        tick();
        data_in = 5'd24;
        tick();
        chk("b24_done", 32'({busy_b, done_b}), 32'b01);

        // read back; default instance contrasts at address 0
        cmd(1'b1, 2'b01, 5'd0, 5'd0, 5'd0);
        tick();
        chk("b24_rd0", 32'(dout_b), 32'd23);
        chk("a_rd0", 32'(dout_a), 32'd0);
        address = 5'd1;
        tick();
        chk("b24_rd1", 32'(dout_b), 32'd24);
        address = 5'd24;
        tick();
        chk("a_rd24", 32'(dout_a), 32'd23);
        chk("b24_oor_rd", 32'({dout_b, ov_b, err_b}), 32'({5'd24, 1'b0, 1'b1}));

        // DEPTH=24 burst read wraps at DEPTH
        cmd(1'b1, 2'b11, 5'd22, 5'd3, 5'd0);
        tick();
        chk("b24_br0", 32'({dout_b, ov_b}), 32'({5'd21, 1'b1}));
        en = 1'b0;
        tick();
        chk("b24_br1", 32'(dout_b), 32'd22);
        tick();
        chk("b24_br2", 32'(dout_b), 32'd23);
        tick();
        chk("b24_br3", 32'({dout_b, ov_b, busy_b, done_b}), 32'({5'd24, 3'b101}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
